// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C command master between NUM_REQ command sources.
// Round-robin arbitration, one command in flight at a time, NACK retry with a fixed
// backoff, a per-transaction watchdog and per-requester done/err pulses.
//
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   req_i         - per-requester request level, held until that requester's done
//   req_cmd_i     - command for requester i in bits [i*CMD_W +: CMD_W]
//   grant_o       - one-hot owner of the current transaction
//   done_o        - one-cycle completion pulse for the owner
//   err_o         - one-cycle failure flag, coincident with done_o
//   m_start_o     - one-cycle start pulse to the I2C master
//   m_cmd_o       - command to the master, stable from m_start_o until m_done_i
//   m_busy_i      - master cannot accept a start
//   m_done_i      - master end-of-transfer pulse
//   m_ack_i       - slave ACK, qualified by m_done_i
//   busy_o        - arbiter is not idle
module i2c_cmd_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CMD_W       = 8,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned RETRY_GAP   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     m_start_o,
  output logic [CMD_W-1:0]         m_cmd_o,
  input  logic                     m_busy_i,
  input  logic                     m_done_i,
  input  logic                     m_ack_i,
  output logic                     busy_o
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One counter serves both the watchdog and the backoff gap.
  localparam int unsigned CntMax = (TIMEOUT_CYC > RETRY_GAP) ? TIMEOUT_CYC : RETRY_GAP;
  localparam int unsigned TimerW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StBackoff,
    StRespond
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [NUM_REQ-1:0]  err_q;
  logic                m_start_q;
  logic [CMD_W-1:0]    m_cmd_q;
  logic [IdxW-1:0]     idx_q;
  logic [IdxW-1:0]     last_grant_q;
  logic [RetryW-1:0]   retry_q;
  logic [TimerW-1:0]   timer_q;

  // Round-robin pick, starting just after the last winner.
  logic                sel_found;
  logic [IdxW-1:0]     sel_idx;
  logic [NUM_REQ-1:0]  sel_oh;
  logic [CMD_W-1:0]    sel_cmd;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    sel_cmd   = '0;
    // Indices above the last winner come first, then the wrap-around.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_i[i] && (i > 32'(last_grant_q))) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        sel_oh[i] = 1'b1;
        sel_cmd   = req_cmd_i[i*CMD_W +: CMD_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_i[i] && (i <= 32'(last_grant_q))) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        sel_oh[i] = 1'b1;
        sel_cmd   = req_cmd_i[i*CMD_W +: CMD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      m_start_q    <= 1'b0;
      m_cmd_q      <= '0;
      idx_q        <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      retry_q      <= '0;
      timer_q      <= '0;
    end else begin
      // Pulse outputs default low; set only on the cycle they are due.
      m_start_q <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            idx_q   <= sel_idx;
            grant_q <= sel_oh;
            m_cmd_q <= sel_cmd;
            retry_q <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!m_busy_i) begin
            m_start_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= StWaitDone;
          end
        end
        StWaitDone: begin
          timer_q <= timer_q + 1'b1;
          // m_done takes priority over a simultaneous watchdog expiry.
          if (m_done_i) begin
            if (m_ack_i) begin
              done_q  <= grant_q;
              state_q <= StRespond;
            end else if (retry_q < RetryW'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              timer_q <= '0;
              state_q <= StBackoff;
            end else begin
              done_q  <= grant_q;
              err_q   <= grant_q;
              state_q <= StRespond;
            end
          end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
            done_q  <= grant_q;
            err_q   <= grant_q;
            state_q <= StRespond;
          end
        end
        StBackoff: begin
          if (timer_q == TimerW'(RETRY_GAP - 1)) begin
            state_q <= StIssue;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRespond: begin
          grant_q      <= '0;
          last_grant_q <= idx_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign m_start_o = m_start_q;
  assign m_cmd_o   = m_cmd_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: table of single transactions, directed
// round-robin / stall / reset sequences, and a randomized run, all compared each
// cycle against a behavioural reference model.
module tb_i2c_cmd_arbiter;
  localparam int unsigned NReq     = 4;
  localparam int unsigned CmdW     = 8;
  localparam int unsigned MaxRetry = 2;
  localparam int unsigned RetryGap = 4;
  localparam int unsigned Timeout  = 64;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NReq-1:0]         req;
  logic [NReq*CmdW-1:0]    req_cmd;
  logic                    m_busy, m_done, m_ack;
  logic [NReq-1:0]         grant, done, err;
  logic                    m_start;
  logic [CmdW-1:0]         m_cmd;
  logic                    busy;

  i2c_cmd_arbiter #(
    .NUM_REQ    (NReq),
    .CMD_W      (CmdW),
    .MAX_RETRY  (MaxRetry),
    .RETRY_GAP  (RetryGap),
    .TIMEOUT_CYC(Timeout)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .req_cmd_i(req_cmd),
    .grant_o  (grant),
    .done_o   (done),
    .err_o    (err),
    .m_start_o(m_start),
    .m_cmd_o  (m_cmd),
    .m_busy_i (m_busy),
    .m_done_i (m_done),
    .m_ack_i  (m_ack),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PhIdle = 0, PhIssue = 1, PhWait = 2, PhGap = 3, PhResp = 4;
  int ph, own, last, tries, age, gap_left;
  logic [NReq-1:0] e_grant, e_done, e_err;
  logic            e_start, e_busy;
  logic [CmdW-1:0] e_cmd;

  function automatic int rr_pick(input int from, input logic [NReq-1:0] r);
    for (int k = 1; k <= int'(NReq); k++) begin
      if (r[(from + k) % int'(NReq)]) return (from + k) % int'(NReq);
    end
    return 0;
  endfunction

  task automatic model_reset();
    ph = PhIdle; own = 0; last = NReq - 1; tries = 0; age = 0; gap_left = 0;
    e_grant = '0; e_done = '0; e_err = '0; e_start = 1'b0; e_busy = 1'b0; e_cmd = '0;
  endtask

  // Advance one clock edge given the inputs sampled at that edge.
  task automatic model_update(input logic [NReq-1:0] r, input logic [NReq*CmdW-1:0] c,
                              input logic b, input logic d, input logic a);
    e_start = 1'b0; e_done = '0; e_err = '0;
    case (ph)
      PhIdle: if (r != '0) begin
        own = rr_pick(last, r); e_cmd = c[own*CmdW +: CmdW]; tries = 0; ph = PhIssue;
      end
      PhIssue: if (!b) begin e_start = 1'b1; age = 0; ph = PhWait; end
      PhWait: begin
        if (d) begin
          if (a) begin
            ph = PhResp; e_done = 4'(1 << own);
          end else begin
            tries++;
            if (tries > int'(MaxRetry)) begin
              ph = PhResp; e_done = 4'(1 << own); e_err = 4'(1 << own);
            end else begin
              ph = PhGap; gap_left = RetryGap;
            end
          end
        end else if (age == int'(Timeout) - 1) begin
          ph = PhResp; e_done = 4'(1 << own); e_err = 4'(1 << own);
        end else begin
          age++;
        end
      end
      PhGap: begin gap_left--; if (gap_left == 0) ph = PhIssue; end
      PhResp: begin last = own; ph = PhIdle; end
      default: ph = PhIdle;
    endcase
    e_grant = (ph != PhIdle) ? 4'(1 << own) : '0;
    e_busy  = (ph != PhIdle);
  endtask

  // ---------------- master model and event tracking ----------------
  typedef struct { int lat; bit ack; } resp_t;
  resp_t resp_q[$];
  bit    random_mode = 1'b0;
  bit    m_active = 1'b0;
  int    m_lat, mcyc;
  bit    m_ackv;

  int n_start = 0;
  int first_start, prev_start, min_gap, done_cyc;
  logic [NReq-1:0] last_done, last_err;
  logic [CmdW-1:0] start_cmd;

  task automatic load_resp();
    resp_t rs;
    int p;
    if (resp_q.size() > 0) begin
      rs = resp_q.pop_front();
    end else if (random_mode) begin
      p = $urandom_range(0, 99);
      if (p < 8)       begin rs.lat = 999; rs.ack = 1'b1; end
      else if (p < 12) begin rs.lat = 64 + (p % 2); rs.ack = 1'b1; end
      else begin rs.lat = $urandom_range(0, 12); rs.ack = ($urandom_range(0, 2) != 0); end
    end else begin
      rs.lat = 2; rs.ack = 1'b1;
    end
    m_active = 1'b1; m_lat = rs.lat; m_ackv = rs.ack; mcyc = 0;
  endtask

  task automatic txn_begin();
    first_start = -1; prev_start = -1; min_gap = 1000000;
  endtask

  task automatic step();
    logic [NReq-1:0]      r_s;
    logic [NReq*CmdW-1:0] c_s;
    logic                 b_s, d_s, a_s;
    r_s = req; c_s = req_cmd; b_s = m_busy; d_s = m_done; a_s = m_ack;
    @(posedge clk);
    model_update(r_s, c_s, b_s, d_s, a_s);
    #1;
    cyc++;
    n_checks++;
    if ({grant, done, err, m_start, m_cmd, busy} !==
        {e_grant, e_done, e_err, e_start, e_cmd, e_busy}) begin
      n_errors++;
      $display("FAIL cycle %0d outputs: got grant=%b done=%b err=%b m_start=%b m_cmd=%h busy=%b, expected grant=%b done=%b err=%b m_start=%b m_cmd=%h busy=%b",
               cyc, grant, done, err, m_start, m_cmd, busy,
               e_grant, e_done, e_err, e_start, e_cmd, e_busy);
    end
    if (m_start === 1'b1) begin
      n_start++;
      start_cmd = m_cmd;
      if (first_start < 0) first_start = cyc;
      else if (cyc - prev_start < min_gap) min_gap = cyc - prev_start;
      prev_start = cyc;
      load_resp();
    end else begin
      mcyc++;
    end
    if (done !== '0) begin done_cyc = cyc; last_done = done; last_err = err; end
    m_done = m_active && (mcyc == m_lat);
    if (m_done) m_active = 1'b0;
    m_ack = m_done ? m_ackv : 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (done !== '0) got = 1'b1;
    end
    check("done_wait", 64'(got), 64'd1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    m_done = 1'b0; m_ack = 1'b0; m_busy = 1'b0; m_active = 1'b0;
    resp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({grant, done, err, m_start, m_cmd, busy}), 64'd0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [NReq-1:0] req;
    int              n_nack;
    int              lat;
    logic [NReq-1:0] exp_done;
    logic [NReq-1:0] exp_err;
    int              exp_starts;
    int              exp_lat;
  } vec_t;

  vec_t            tbl[10];
  logic [NReq-1:0] rr_exp[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, idx, prev_done;
    // Table chained from reset (requester 0 first); lat 999 = master never answers.
    tbl[0] = '{4'b0001, 0, 10,  4'b0001, 4'b0000, 1, 11};
    tbl[1] = '{4'b0100, 2, 5,   4'b0100, 4'b0000, 3, -1};
    tbl[2] = '{4'b0100, 3, 0,   4'b0100, 4'b0100, 3, -1};
    tbl[3] = '{4'b1111, 0, 4,   4'b1000, 4'b0000, 1, 5};
    tbl[4] = '{4'b0110, 0, 1,   4'b0010, 4'b0000, 1, 2};
    tbl[5] = '{4'b0011, 0, 7,   4'b0001, 4'b0000, 1, 8};
    tbl[6] = '{4'b1000, 0, 999, 4'b1000, 4'b1000, 1, 64};
    tbl[7] = '{4'b1001, 0, 63,  4'b0001, 4'b0000, 1, 64};
    tbl[8] = '{4'b0001, 0, 64,  4'b0001, 4'b0001, 1, 64};
    tbl[9] = '{4'b1010, 0, 0,   4'b0010, 4'b0000, 1, 1};
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    req = '0; req_cmd = '0; m_busy = 1'b0; m_done = 1'b0; m_ack = 1'b0;
    apply_reset();

    // Table-driven single transactions.
    for (int v = 0; v < 10; v++) begin
      txn_begin();
      s0 = n_start;
      for (int n = 0; n < tbl[v].n_nack; n++) resp_q.push_back('{3, 1'b0});
      if (tbl[v].n_nack <= int'(MaxRetry)) resp_q.push_back('{tbl[v].lat, 1'b1});
      req_cmd = $urandom;
      req = tbl[v].req;
      run_until_done(400);
      check($sformatf("tbl%0d_done", v), 64'(last_done), 64'(tbl[v].exp_done));
      check($sformatf("tbl%0d_err", v), 64'(last_err), 64'(tbl[v].exp_err));
      check($sformatf("tbl%0d_starts", v), 64'(n_start - s0), 64'(tbl[v].exp_starts));
      idx = 0;
      for (int i = 0; i < int'(NReq); i++) if (tbl[v].exp_done[i]) idx = i;
      check($sformatf("tbl%0d_cmd", v), 64'(start_cmd), 64'(req_cmd[idx*CmdW +: CmdW]));
      // NACK at cycle 3, RetryGap backoff cycles, one issue cycle, then the next start.
      if (tbl[v].exp_starts > 1)
        check($sformatf("tbl%0d_retry_gap", v), 64'(min_gap), 64'(3 + 1 + RetryGap + 1));
      if (tbl[v].exp_lat >= 0)
        check($sformatf("tbl%0d_latency", v), 64'(done_cyc - first_start),
              64'(tbl[v].exp_lat));
      req = '0;
      resp_q.delete();
      step();
      step();
      check($sformatf("tbl%0d_idle", v), 64'(busy), 64'd0);
    end

    // Round-robin with req=1011 held; requester 2 never requests.
    req = '0;
    apply_reset();
    req_cmd = $urandom;
    req = 4'b1011;
    prev_done = -1;
    for (int k = 0; k < 6; k++) begin
      txn_begin();
      run_until_done(100);
      check($sformatf("rr%0d_done", k), 64'(last_done), 64'(rr_exp[k]));
      check($sformatf("rr%0d_err", k), 64'(last_err), 64'd0);
      if (k > 0) check($sformatf("rr%0d_turnaround", k), 64'(first_start - prev_done), 64'd3);
      prev_done = done_cyc;
    end
    req = '0;
    step();
    step();

    // Master busy stall, then a transaction that times out.
    apply_reset();
    txn_begin();
    m_busy = 1'b1;
    req = 4'b0001;
    s0 = n_start;
    repeat (20) step();
    check("stall_no_start", 64'(n_start - s0), 64'd0);
    check("stall_grant", 64'(grant), 64'b0001);
    m_busy = 1'b0;
    resp_q.push_back('{999, 1'b1});
    run_until_done(200);
    check("stall_starts", 64'(n_start - s0), 64'd1);
    check("timeout_latency", 64'(done_cyc - first_start), 64'(Timeout));
    check("timeout_err", 64'(last_err), 64'b0001);
    req = '0;
    step();
    step();

    // Reset asserted in the middle of WAIT_DONE.
    req_cmd = $urandom;
    req = 4'b0010;
    resp_q.push_back('{30, 1'b1});
    txn_begin();
    for (int i = 0; i < 10; i++) step();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 64'({grant, done, err, m_start, m_cmd, busy}), 64'd0);
    model_reset();
    m_active = 1'b0; m_done = 1'b0; m_ack = 1'b0;
    resp_q.delete();
    req = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("rst_first_grant", 64'(grant), 64'b0001);
    run_until_done(100);
    check("rst_first_done", 64'(last_done), 64'b0001);
    req = '0;
    step();
    step();

    // Randomized traffic, busy stalls, NACKs, timeouts and stray m_done pulses.
    apply_reset();
    random_mode = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      for (int i = 0; i < int'(NReq); i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 99) < 15) begin
            req[i] = 1'b1;
            req_cmd[i*CmdW +: CmdW] = 8'($urandom);
          end
        end else if ($urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 19) == 0) req_cmd[i*CmdW +: CmdW] = 8'($urandom);
      end
      m_busy = ($urandom_range(0, 3) == 0);
      step();
    end
    random_mode = 1'b0;
    m_busy = 1'b0;
    req = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
